// File: rtl/boss_motion.sv
// Boss rectangle for the 640x480 renderer: bounces once per frame inside the active
// area and tracks hit points through an IDLE/MOVE/FLASH/DEAD state machine.
module boss_motion #(
    parameter int X_MIN        = 144,
    parameter int X_MAX        = 783,
    parameter int Y_MIN        = 31,
    parameter int Y_MAX        = 510,
    parameter int BOSS_W       = 64,
    parameter int BOSS_H       = 48,
    parameter int SPEED_X      = 2,
    parameter int SPEED_Y      = 1,
    parameter int START_X      = 400,
    parameter int START_Y      = 100,
    parameter int HP_INIT      = 8,
    parameter int FLASH_FRAMES = 4
) (
    input  logic       dclk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       enable,
    input  logic       hit,
    output logic [9:0] bossX,
    output logic [8:0] bossY,
    output logic [9:0] bossW,
    output logic [8:0] bossH,
    output logic [3:0] boss_hp,
    output logic       boss_flash,
    output logic       boss_dead,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        FLASH = 2'd2,
        DEAD  = 2'd3
    } state_t;

    localparam logic [10:0] XMIN11 = 11'(X_MIN);
    localparam logic [10:0] XMAX11 = 11'(X_MAX);
    localparam logic [10:0] YMIN11 = 11'(Y_MIN);
    localparam logic [10:0] YMAX11 = 11'(Y_MAX);
    localparam logic [10:0] SX11   = 11'(SPEED_X);
    localparam logic [10:0] SY11   = 11'(SPEED_Y);
    localparam logic [10:0] W11    = 11'(BOSS_W);
    localparam logic [10:0] H11    = 11'(BOSS_H);

    state_t     state_q, state_d;
    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic       left_q, left_d;
    logic       up_q, up_d;
    logic [3:0] hp_q, hp_d;
    logic [3:0] flash_cnt_q, flash_cnt_d;
    logic       vs_q;

    logic        frame_tick;
    logic        move_ok;
    logic [10:0] x_ext, y_ext;

    // Rising edge of active-low vsync: end of sync pulse, still inside vertical blanking.
    assign frame_tick = vsync & ~vs_q;
    assign move_ok    = frame_tick & enable & ((state_q == MOVE) | (state_q == FLASH));
    assign x_ext      = {1'b0, x_q};
    assign y_ext      = {2'b00, y_q};

    always_comb begin
        x_d    = x_q;
        left_d = left_q;
        if (move_ok) begin
            if (!left_q) begin
                if (x_ext + SX11 + W11 > XMAX11) begin
                    x_d    = 10'(X_MAX - BOSS_W);
                    left_d = 1'b1;
                end else begin
                    x_d = 10'(x_ext + SX11);
                end
            end else if (x_ext < XMIN11 + SX11) begin
                x_d    = 10'(X_MIN);
                left_d = 1'b0;
            end else begin
                x_d = 10'(x_ext - SX11);
            end
        end
    end

    always_comb begin
        y_d  = y_q;
        up_d = up_q;
        if (move_ok) begin
            if (!up_q) begin
                if (y_ext + SY11 + H11 > YMAX11) begin
                    y_d  = 9'(Y_MAX - BOSS_H);
                    up_d = 1'b1;
                end else begin
                    y_d = 9'(y_ext + SY11);
                end
            end else if (y_ext < YMIN11 + SY11) begin
                y_d  = 9'(Y_MIN);
                up_d = 1'b0;
            end else begin
                y_d = 9'(y_ext - SY11);
            end
        end
    end

    // A hit arriving together with a tick in MOVE leaves flash_cnt full, so the
    // countdown begins on the following tick.
    always_comb begin
        state_d     = state_q;
        hp_d        = hp_q;
        flash_cnt_d = flash_cnt_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = MOVE;
            end
            MOVE: begin
                if (hit) begin
                    if (hp_q > 4'd1) begin
                        hp_d        = hp_q - 4'd1;
                        flash_cnt_d = 4'(FLASH_FRAMES);
                        state_d     = FLASH;
                    end else begin
                        hp_d    = 4'd0;
                        state_d = DEAD;
                    end
                end
            end
            FLASH: begin
                if (frame_tick) begin
                    if (flash_cnt_q == 4'd1) begin
                        flash_cnt_d = 4'd0;
                        state_d     = MOVE;
                    end else begin
                        flash_cnt_d = flash_cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = DEAD;
            end
        endcase
    end

    always_ff @(posedge dclk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= 10'(START_X);
            y_q         <= 9'(START_Y);
            left_q      <= 1'b0;
            up_q        <= 1'b0;
            hp_q        <= 4'(HP_INIT);
            flash_cnt_q <= 4'd0;
            vs_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            left_q      <= left_d;
            up_q        <= up_d;
            hp_q        <= hp_d;
            flash_cnt_q <= flash_cnt_d;
            vs_q        <= vsync;
        end
    end

    assign bossX      = x_q;
    assign bossY      = y_q;
    assign bossW      = 10'(BOSS_W);
    assign bossH      = 9'(BOSS_H);
    assign boss_hp    = hp_q;
    assign boss_flash = (state_q == FLASH);
    assign boss_dead  = (state_q == DEAD);
    assign state_dbg  = state_q;

endmodule
